// File: rtl/cache_arbiter.sv
// Round-robin arbiter between the I-cache and the D-cache for the single physical-memory port.
// One full-line transaction at a time. Each transaction is followed by one quiet recovery cycle.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction; grant on any request
// SERVE_I | pmem command driven from the latched I-cache request
// SERVE_D | pmem command driven from the latched D-cache request
// RECOVER | one quiet cycle so the served cache can drop its request
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_arb_mem_read,
  input  logic [ADDR_W-1:0] i_arb_mem_address,
  output logic [LINE_W-1:0] i_arb_mem_rdata,
  output logic              i_arb_mem_resp,
  input  logic              d_arb_mem_read,
  input  logic              d_arb_mem_write,
  input  logic [ADDR_W-1:0] d_arb_mem_address,
  input  logic [LINE_W-1:0] d_arb_mem_wdata,
  output logic [LINE_W-1:0] d_arb_mem_rdata,
  output logic              d_arb_mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} state_t;

  state_t            state, state_nx;
  logic              last_grant, last_grant_nx;
  logic [ADDR_W-1:0] req_addr, req_addr_nx;
  logic [LINE_W-1:0] req_wdata, req_wdata_nx;
  logic              req_write, req_write_nx;
  logic              i_req, d_req, grant_d;

  assign i_req = i_arb_mem_read;
  assign d_req = d_arb_mem_read | d_arb_mem_write;

  assign i_arb_mem_rdata = pmem_rdata;
  assign d_arb_mem_rdata = pmem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_write  <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      req_addr   <= req_addr_nx;
      req_wdata  <= req_wdata_nx;
      req_write  <= req_write_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    last_grant_nx  = last_grant;
    req_addr_nx    = req_addr;
    req_wdata_nx   = req_wdata;
    req_write_nx   = req_write;
    grant_d        = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    pmem_address   = '0;
    pmem_wdata     = '0;
    i_arb_mem_resp = 1'b0;
    d_arb_mem_resp = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          // On contention D wins unless D was the previous grant.
          grant_d       = d_req && (!i_req || !last_grant);
          last_grant_nx = grant_d;
          if (grant_d) begin
            state_nx     = SERVE_D;
            req_addr_nx  = d_arb_mem_address;
            req_wdata_nx = d_arb_mem_wdata;
            req_write_nx = d_arb_mem_write;
          end else begin
            state_nx     = SERVE_I;
            req_addr_nx  = i_arb_mem_address;
            req_wdata_nx = '0;
            req_write_nx = 1'b0;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        pmem_read    = !req_write;
        pmem_write   = req_write;
        pmem_address = req_addr;
        pmem_wdata   = req_wdata;
        if (pmem_resp) begin
          i_arb_mem_resp = (state == SERVE_I);
          d_arb_mem_resp = (state == SERVE_D);
          state_nx       = RECOVER;
        end
      end
      RECOVER: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized transactions
// checked against a rule-level model of the round-robin grant.
module tb_cache_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_arb_mem_read = 1'b0;
  logic [AW-1:0] i_arb_mem_address = '0;
  logic [LW-1:0] i_arb_mem_rdata;
  logic          i_arb_mem_resp;
  logic          d_arb_mem_read = 1'b0;
  logic          d_arb_mem_write = 1'b0;
  logic [AW-1:0] d_arb_mem_address = '0;
  logic [LW-1:0] d_arb_mem_wdata = '0;
  logic [LW-1:0] d_arb_mem_rdata;
  logic          d_arb_mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  int   errors = 0;
  int   checks = 0;
  logic model_last = 1'b0;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_arb_mem_read(i_arb_mem_read), .i_arb_mem_address(i_arb_mem_address),
    .i_arb_mem_rdata(i_arb_mem_rdata), .i_arb_mem_resp(i_arb_mem_resp),
    .d_arb_mem_read(d_arb_mem_read), .d_arb_mem_write(d_arb_mem_write),
    .d_arb_mem_address(d_arb_mem_address), .d_arb_mem_wdata(d_arb_mem_wdata),
    .d_arb_mem_rdata(d_arb_mem_rdata), .d_arb_mem_resp(d_arb_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Grant rule: a lone requester wins; on contention, the one not granted last time wins.
  function automatic logic pick(input logic i_req, input logic d_req);
    if (i_req && d_req) return ~model_last;
    return d_req;
  endfunction

  task automatic check_cmd(input string tag, input logic ew, input logic [AW-1:0] ea,
                           input logic [LW-1:0] ed);
    chk({tag, "_pmem_write"}, LW'(pmem_write), LW'(ew));
    chk({tag, "_pmem_read"}, LW'(pmem_read), LW'(!ew));
    chk({tag, "_pmem_address"}, LW'(pmem_address), LW'(ea));
    if (ew) chk({tag, "_pmem_wdata"}, pmem_wdata, ed);
    chk({tag, "_resps_idle"}, LW'({i_arb_mem_resp, d_arb_mem_resp}), LW'(2'b00));
  endtask

  // Runs one transaction from the current request lines; returns in the recovery cycle.
  task automatic serve(input int exp_wait, input int lat, input logic [LW-1:0] rdata);
    logic          ep, ew;
    logic [AW-1:0] ea;
    logic [LW-1:0] ed;
    int            n;
    ep = pick(i_arb_mem_read, d_arb_mem_read | d_arb_mem_write);
    ew = ep & d_arb_mem_write;
    ea = ep ? d_arb_mem_address : i_arb_mem_address;
    ed = d_arb_mem_wdata;
    n  = 0;
    while (!(pmem_read || pmem_write) && n < 8) begin
      tick();
      n++;
    end
    chk("grant_wait", LW'(n), LW'(exp_wait));
    check_cmd("grant", ew, ea, ed);
    repeat (lat) begin
      // Disturb only the waiting cache's inputs; the latched command must not move.
      if (ep) i_arb_mem_address = AW'($urandom);
      else begin
        d_arb_mem_address = AW'($urandom);
        d_arb_mem_wdata   = rand_line();
      end
      tick();
      check_cmd("hold", ew, ea, ed);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = rdata;
    #1;
    chk("i_resp", LW'(i_arb_mem_resp), LW'(!ep));
    chk("d_resp", LW'(d_arb_mem_resp), LW'(ep));
    chk("i_rdata", i_arb_mem_rdata, rdata);
    chk("d_rdata", d_arb_mem_rdata, rdata);
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = rand_line();
    #1;
    chk("recover_cmd", LW'({pmem_read, pmem_write}), LW'(2'b00));
    chk("recover_resp", LW'({i_arb_mem_resp, d_arb_mem_resp}), LW'(2'b00));
    pmem_resp = 1'b1;
    #1;
    chk("recover_spurious", LW'({i_arb_mem_resp, d_arb_mem_resp}), LW'(2'b00));
    pmem_resp  = 1'b0;
    model_last = ep;
  endtask

  initial begin
    int n;
    int r;
    // Reset held with both caches requesting.
    i_arb_mem_read    = 1'b1;
    i_arb_mem_address = 16'h1111;
    d_arb_mem_read    = 1'b1;
    d_arb_mem_address = 16'h2222;
    repeat (3) tick();
    chk("rst_cmd", LW'({pmem_read, pmem_write}), LW'(2'b00));
    chk("rst_resp", LW'({i_arb_mem_resp, d_arb_mem_resp}), LW'(2'b00));
    chk("rst_addr", LW'(pmem_address), LW'(0));
    chk("rst_wdata", pmem_wdata, LW'(0));
    rst_n      = 1'b1;
    model_last = 1'b0;
    serve(1, 2, rand_line());

    // Single I read, five-cycle memory latency.
    d_arb_mem_read    = 1'b0;
    i_arb_mem_read    = 1'b1;
    i_arb_mem_address = 16'h1230;
    serve(2, 5, {32'hDEAD_0000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_BEEF});
    i_arb_mem_read = 1'b0;

    // Contention for four transactions.
    i_arb_mem_read = 1'b1;
    d_arb_mem_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve(2, $urandom_range(1, 4), rand_line());
      i_arb_mem_address = AW'($urandom);
      d_arb_mem_address = AW'($urandom);
    end
    i_arb_mem_read = 1'b0;
    d_arb_mem_read = 1'b0;

    // Write-back then allocate.
    d_arb_mem_write   = 1'b1;
    d_arb_mem_address = 16'h4000;
    d_arb_mem_wdata   = {8{16'hAAAA}};
    serve(2, 3, rand_line());
    d_arb_mem_write   = 1'b0;
    d_arb_mem_read    = 1'b1;
    d_arb_mem_address = 16'h4100;
    serve(2, 2, rand_line());

    // Read and write together: a write.
    d_arb_mem_write   = 1'b1;
    d_arb_mem_address = 16'h5550;
    d_arb_mem_wdata   = rand_line();
    serve(2, 1, rand_line());
    d_arb_mem_read  = 1'b0;
    d_arb_mem_write = 1'b0;

    // Randomized transactions.
    for (int k = 0; k < 16; k++) begin
      r = $urandom_range(1, 3);
      i_arb_mem_read    = r[0];
      d_arb_mem_read    = 1'b0;
      d_arb_mem_write   = 1'b0;
      if (r[1]) begin
        r = $urandom_range(1, 3);
        d_arb_mem_read  = r[0];
        d_arb_mem_write = r[1];
      end
      i_arb_mem_address = AW'($urandom);
      d_arb_mem_address = AW'($urandom);
      d_arb_mem_wdata   = rand_line();
      serve(2, $urandom_range(1, 6), rand_line());
    end
    i_arb_mem_read  = 1'b0;
    d_arb_mem_read  = 1'b0;
    d_arb_mem_write = 1'b0;

    // Reset during SERVE_I.
    i_arb_mem_read    = 1'b1;
    i_arb_mem_address = AW'($urandom);
    n = 0;
    while (!pmem_read && n < 8) begin
      tick();
      n++;
    end
    chk("midrst_grant_wait", LW'(n), LW'(2));
    tick();
    chk("midrst_serving", LW'(pmem_read), LW'(1));
    rst_n          = 1'b0;
    i_arb_mem_read = 1'b0;
    tick();
    chk("midrst_abort_cmd", LW'({pmem_read, pmem_write}), LW'(2'b00));
    chk("midrst_abort_addr", LW'(pmem_address), LW'(0));
    chk("midrst_no_resp", LW'({i_arb_mem_resp, d_arb_mem_resp}), LW'(2'b00));
    pmem_resp = 1'b1;
    #1;
    chk("midrst_late_resp", LW'({i_arb_mem_resp, d_arb_mem_resp}), LW'(2'b00));
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_late_resp", LW'({i_arb_mem_resp, d_arb_mem_resp}), LW'(2'b00));
    chk("idle_no_cmd", LW'({pmem_read, pmem_write}), LW'(2'b00));
    pmem_resp = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
